// File: rtl/seg_wr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_wr_scheduler_if
// Description : Bundles the memory-map controls, the AFU source stream and
//               the DMA write channel of seg_wr_scheduler.
//               master modport : host/datapath/DMA side (drives go, bases,
//                                src_valid/src_data, wr_full, wr_resp)
//               slave modport  : the scheduler itself
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_wr_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 16
);
    logic                  go;
    logic [CNT_WIDTH-1:0]  num_lines;
    logic [ADDR_WIDTH-1:0] wr_addr_s0;
    logic [ADDR_WIDTH-1:0] wr_addr_s1;
    logic [ADDR_WIDTH-1:0] wr_addr_s2;
    logic [ADDR_WIDTH-1:0] wr_addr_s3;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic                  wr_resp;
    logic                  done;
    logic [ADDR_WIDTH-1:0] cv_value;

    modport master (
        output go, num_lines, wr_addr_s0, wr_addr_s1, wr_addr_s2, wr_addr_s3,
        output src_valid, src_data, wr_full, wr_resp,
        input  src_ready, wr_en, wr_addr, wr_data, done, cv_value
    );

    modport slave (
        input  go, num_lines, wr_addr_s0, wr_addr_s1, wr_addr_s2, wr_addr_s3,
        input  src_valid, src_data, wr_full, wr_resp,
        output src_ready, wr_en, wr_addr, wr_data, done, cv_value
    );
endinterface
`default_nettype wire

// File: rtl/seg_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_wr_scheduler
// Description : On go, pulls 4*num_lines cachelines from the datapath and
//               issues them as DMA writes interleaved over four segments
//               (s0,s1,s2,s3,s0,...), then waits for every write response
//               and raises done. cv_value reports busy cycles (saturating).
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               bus  - seg_wr_if slave (controls, source stream, DMA channel)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_wr_scheduler #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int LINE_BYTES = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    seg_wr_if.slave    bus
);
    localparam int TOT_WIDTH = CNT_WIDTH + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q [4];
    logic [ADDR_WIDTH-1:0] ptr_d [4];
    logic [TOT_WIDTH-1:0]  total_q, total_d;
    logic [TOT_WIDTH-1:0]  issued_q, issued_d;
    logic [TOT_WIDTH-1:0]  acked_q, acked_d;
    logic [1:0]            seg_q, seg_d;
    logic [ADDR_WIDTH-1:0] cv_q, cv_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic start_w;
    logic ready_w;
    logic done_w;
    logic fire_w;
    logic active_w;

    // go is only honoured when no transfer is in flight
    assign start_w  = bus.go && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign fire_w   = bus.src_valid && ready_w;
    assign active_w = (state_q == S_ISSUE) || (state_q == S_DRAIN);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_w)
                    state_d = (bus.num_lines == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (fire_w && (issued_q + TOT_WIDTH'(1) == total_q))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (acked_q == total_q)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready_w = 1'b0;
        done_w  = 1'b0;
        case (state_q)
            S_ISSUE: ready_w = !bus.wr_full && (issued_q < total_q);
            S_DONE:  done_w  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d     = ptr_q;
        total_d   = total_q;
        issued_d  = issued_q;
        acked_d   = acked_q;
        seg_d     = seg_q;
        cv_d      = cv_q;
        wr_en_d   = fire_w;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (fire_w) begin
            wr_addr_d      = ptr_q[seg_q];
            wr_data_d      = bus.src_data;
            ptr_d[seg_q]   = ptr_q[seg_q] + ADDR_WIDTH'(LINE_BYTES);
            seg_d          = seg_q + 2'd1;
            issued_d       = issued_q + TOT_WIDTH'(1);
        end

        if (active_w) begin
            // responses past the expected total are dropped
            if (bus.wr_resp && (acked_q < total_q))
                acked_d = acked_q + TOT_WIDTH'(1);
            if (cv_q != '1)
                cv_d = cv_q + ADDR_WIDTH'(1);
        end

        if (start_w) begin
            ptr_d[0] = bus.wr_addr_s0;
            ptr_d[1] = bus.wr_addr_s1;
            ptr_d[2] = bus.wr_addr_s2;
            ptr_d[3] = bus.wr_addr_s3;
            total_d  = {bus.num_lines, 2'b00};
            issued_d = '0;
            acked_d  = '0;
            seg_d    = '0;
            cv_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ptr_q[i] <= '0;
            total_q   <= '0;
            issued_q  <= '0;
            acked_q   <= '0;
            seg_q     <= '0;
            cv_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            total_q   <= total_d;
            issued_q  <= issued_d;
            acked_q   <= acked_d;
            seg_q     <= seg_d;
            cv_q      <= cv_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.src_ready = ready_w;
    assign bus.done      = done_w;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cv_value  = cv_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_wr_scheduler
// Description : Self-checking bench for seg_wr_scheduler. Each transfer is
//               predicted from the segment rules: the i-th write goes to
//               base[i%4] + (i/4)*64 carrying the i-th consumed line, one
//               write per consumed line, done two cycles after the final
//               response, cv_value = edges from go to done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_wr_scheduler;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seg_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    seg_wr_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BYTES(64), .CNT_WIDTH(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic idle_inputs();
        bus.go        = 1'b0;
        bus.src_valid = 1'b0;
        bus.wr_full   = 1'b0;
        bus.wr_resp   = 1'b0;
    endtask

    // full_mode: 0 never full, 1 full on odd cycles, 2 random
    // mid_go: cycle index for an extra (ignored) go pulse, -1 for none
    // abort_at: stop driving after this cycle without waiting for done (0 = run to done)
    task automatic run_transfer(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                                input logic [AW-1:0] b2, input logic [AW-1:0] b3,
                                input int nl, input int full_mode, input int vprob,
                                input int rdelay, input int mid_go, input int abort_at);
        logic [AW-1:0] bs [4];
        logic [AW-1:0] exp_addr [$];
        logic [DW-1:0] exp_data [$];
        int            resp_due [$];
        logic [DW-1:0] cur;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int total, fired, resps, last_resp, done_cyc, cyc;
        logic exp_ready, prev_fire, fire, exp_done;

        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        total = 4 * nl;
        for (int i = 0; i < total; i++)
            exp_addr.push_back(bs[i % 4] + AW'(i / 4) * AW'(64));
        fired = 0; resps = 0; last_resp = -100; done_cyc = -1; prev_fire = 1'b0;
        cur = rand_line();

        for (cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            bus.go = (cyc == 0) || (cyc == mid_go);
            if (cyc == 0) begin
                bus.num_lines  = CW'(nl);
                bus.wr_addr_s0 = b0; bus.wr_addr_s1 = b1;
                bus.wr_addr_s2 = b2; bus.wr_addr_s3 = b3;
            end else begin
                // bases/count are latched; scramble them to prove it
                bus.num_lines  = CW'($urandom_range(0, 7));
                bus.wr_addr_s0 = {$urandom(), $urandom()};
                bus.wr_addr_s1 = {$urandom(), $urandom()};
                bus.wr_addr_s2 = {$urandom(), $urandom()};
                bus.wr_addr_s3 = {$urandom(), $urandom()};
            end
            case (full_mode)
                1:       bus.wr_full = cyc[0];
                2:       bus.wr_full = ($urandom_range(0, 3) == 0);
                default: bus.wr_full = 1'b0;
            endcase
            bus.src_valid = ($urandom_range(0, 99) < vprob);
            bus.src_data  = cur;
            bus.wr_resp   = 1'b0;
            if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
                void'(resp_due.pop_front());
                bus.wr_resp = 1'b1;
                resps++;
                last_resp = cyc;
            end
            #1;
            exp_ready = (cyc >= 1) && (fired < total) && !bus.wr_full;
            chk("src_ready", DW'(bus.src_ready), DW'(exp_ready));
            chk("wr_en", DW'(bus.wr_en), DW'(prev_fire));
            if (bus.wr_en && exp_addr.size() > 0 && exp_data.size() > 0) begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                chk("wr_addr", DW'(bus.wr_addr), DW'(ea));
                chk("wr_data", bus.wr_data, ed);
                resp_due.push_back(cyc + 1 + rdelay);
            end
            if (cyc >= 1) begin
                exp_done = (total == 0) ? 1'b1 : ((resps == total) && (cyc >= last_resp + 2));
                chk("done", DW'(bus.done), DW'(exp_done));
                if (bus.done && done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("cv_value", DW'(bus.cv_value), DW'(cyc - 1));
                end
            end
            fire = bus.src_valid && exp_ready;
            if (fire) begin
                exp_data.push_back(cur);
                cur = rand_line();
                fired++;
            end
            prev_fire = fire;
            if (abort_at > 0 && cyc == abort_at) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
                chk("cv_frozen", DW'(bus.cv_value), DW'(done_cyc - 1));
                chk("writes_left", DW'(exp_addr.size()), DW'(0));
                break;
            end
        end
        if (abort_at == 0 && done_cyc < 0) chk("timeout_done", DW'(0), DW'(1));
        bus.go = 1'b0;
        bus.src_valid = 1'b0;
        bus.wr_resp = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bus.num_lines  = '0;
        bus.src_data   = '0;
        bus.wr_addr_s0 = '0; bus.wr_addr_s1 = '0;
        bus.wr_addr_s2 = '0; bus.wr_addr_s3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", DW'(bus.src_ready), DW'(0));
        chk("rst_wr_en", DW'(bus.wr_en), DW'(0));
        chk("rst_done",  DW'(bus.done), DW'(0));
        chk("rst_cv",    DW'(bus.cv_value), DW'(0));
        rst = 1'b0;

        // basic interleave, immediate responses
        run_transfer(64'h1000, 64'h2000, 64'h3000, 64'h4000, 2, 0, 100, 0, -1, 0);
        // empty transfer
        run_transfer(64'h5000, 64'h6000, 64'h7000, 64'h8000, 0, 0, 100, 0, -1, 0);
        // backpressure toggling every other cycle
        run_transfer(64'h10000, 64'h20000, 64'h30000, 64'h40000, 3, 1, 60, 0, -1, 0);
        // delayed responses
        run_transfer(64'hA000, 64'hB000, 64'hC000, 64'hD000, 1, 0, 100, 20, -1, 0);
        // go pulsed mid-transfer is ignored
        run_transfer(64'h100, 64'h200, 64'h300, 64'h400, 3, 2, 50, 2, 5, 0);

        // abort mid-transfer with asynchronous reset
        run_transfer(64'h9000, 64'h9100, 64'h9200, 64'h9300, 4, 0, 100, 3, -1, 8);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_ready",   DW'(bus.src_ready), DW'(0));
        chk("abort_wr_en",   DW'(bus.wr_en), DW'(0));
        chk("abort_wr_addr", DW'(bus.wr_addr), DW'(0));
        chk("abort_wr_data", bus.wr_data, DW'(0));
        chk("abort_done",    DW'(bus.done), DW'(0));
        chk("abort_cv",      DW'(bus.cv_value), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        // stale responses in IDLE must not start or finish anything
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.wr_resp = 1'b1;
            #1;
            chk("idle_done", DW'(bus.done), DW'(0));
        end
        bus.wr_resp = 1'b0;

        // pointer wrap on segment 0
        run_transfer(64'hFFFF_FFFF_FFFF_FFC0, 64'h2000, 64'h3000, 64'h4000, 2, 0, 100, 0, -1, 0);
        // back-to-back: go while in DONE with fresh bases
        run_transfer(64'h7700, 64'h8800, 64'h9900, 64'hAA00, 1, 0, 100, 1, -1, 0);
        // randomized transfers
        for (int t = 0; t < 6; t++) begin
            run_transfer({$urandom(), $urandom()} & ~64'h3F, {$urandom(), $urandom()} & ~64'h3F,
                         {$urandom(), $urandom()} & ~64'h3F, {$urandom(), $urandom()} & ~64'h3F,
                         $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(30, 100),
                         $urandom_range(0, 6), -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
